// File: rtl/snn_pkg.sv
// +-----------------------------------------------------------------+
// | snn_pkg: shared widths, event record and encoder FSM states.     |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

package snn_pkg;

  localparam int NUM_NEURONS = 8;
  localparam int TS_W        = 8;
  localparam int ADDR_W      = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] addr;
  } event_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/spike_event_fifo.sv
// +-----------------------------------------------------------------+
// | spike_event_fifo: first-word-fall-through event queue.           |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module spike_event_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 11,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [LW-1:0] cnt_q;
  logic          w_push;
  logic          w_pop;

  // A full queue refuses pushes even when a pop frees a slot on the same edge.
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (w_push) wr_q <= wr_q + PW'(1);
      if (w_pop)  rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + LW'(w_push) - LW'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spike_aer_encoder.sv
// +-----------------------------------------------------------------+
// | spike_aer_encoder: spike frames -> timestamped AER event stream. |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
`default_nettype none

module spike_aer_encoder
  import snn_pkg::*;
#(
  parameter int NUM_NEURONS = snn_pkg::NUM_NEURONS,
  parameter int TS_W        = snn_pkg::TS_W,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_NEURONS-1:0]       spike_vec,
  input  logic                         spike_valid,
  output logic                         spike_ready,
  output logic [$clog2(NUM_NEURONS)-1:0] ev_addr,
  output logic [TS_W-1:0]              ev_ts,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         busy
);

  localparam int AW = $clog2(NUM_NEURONS);

  state_e                 state_q, state_d;
  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [TS_W-1:0]        frame_ts_q, frame_ts_d;
  logic [AW-1:0]          low_idx;
  logic [NUM_NEURONS-1:0] pending_clr;
  logic                   push;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   accept;
  logic [TS_W+AW-1:0]     head;

  assign accept      = spike_valid && spike_ready;
  assign spike_ready = (state_q == ST_IDLE);
  assign pending_clr = pending_q & (pending_q - NUM_NEURONS'(1));
  assign ev_valid    = !fifo_empty;
  assign busy        = (state_q == ST_SCAN) || !fifo_empty;
  assign ev_ts       = head[TS_W+AW-1:AW];
  assign ev_addr     = head[AW-1:0];

  always_comb begin
    low_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = AW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ts_d       = ts_q;
    frame_ts_d = frame_ts_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ts_d       = ts_q + TS_W'(1);
          frame_ts_d = ts_q;
          if (spike_vec != '0) begin
            pending_d = spike_vec;
            state_d   = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (!fifo_full) begin
          push      = 1'b1;
          pending_d = pending_clr;
          if (pending_clr == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      ts_q       <= '0;
      frame_ts_q <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ts_q       <= ts_d;
      frame_ts_q <= frame_ts_d;
    end
  end

  spike_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (TS_W + AW),
    .LW    ($clog2(FIFO_DEPTH) + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i ({frame_ts_q, low_idx}),
    .pop_i   (ev_ready),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

endmodule

`default_nettype wire

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 8: width of the spike vector from the neuron array.
REQ-002 SHALL have parameter TS_W, default 8: width of the timestep stamp.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries, power of two.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port spike_vec, input, NUM_NEURONS: one bit per neuron, 1 = fired this timestep.
REQ-007 SHALL have port spike_valid, input, 1: spike_vec holds a complete timestep frame.
REQ-008 SHALL have port spike_ready, output, 1: the encoder can accept a frame.
REQ-009 SHALL have port ev_addr, output, log2(NUM_NEURONS): neuron index of the head event.
REQ-010 SHALL have port ev_ts, output, TS_W: timestep stamp of the head event.
REQ-011 SHALL have port ev_valid, output, 1: the head event is valid.
REQ-012 SHALL have port ev_ready, input, 1: the consumer accepts the head event.
REQ-013 SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-014 SHALL have port busy, output, 1: the FSM is in SCAN or the FIFO is non-empty.

Function
REQ-015 SHALL accept a frame on any rising edge where spike_valid && spike_ready.
REQ-016 SHALL assert spike_ready exactly when the FSM is in IDLE.
REQ-017 SHALL keep an internal TS_W-bit timestep counter that increments by 1 on every accepted frame, including all-zero frames, and wraps from 2^TS_W-1 to 0.
REQ-018 SHALL stamp every event of an accepted frame with the counter value held before that frame's increment.
REQ-019 SHALL implement two FSM states, IDLE and SCAN:
- IDLE to SCAN on an accepted non-zero frame, latching spike_vec into a pending register.
- An accepted all-zero frame stays in IDLE and produces no event.
REQ-020 In SCAN, on each cycle the FIFO is not full, SHALL push the event for the lowest-index set pending bit and clear that bit.
REQ-021 In SCAN with the FIFO full, SHALL push nothing and hold the pending register unchanged.
REQ-022 SHALL return from SCAN to IDLE on the edge that pushes the last pending bit, so spike_ready is high in the following cycle.
REQ-023 SHALL emit the events of one frame in ascending address order, and all events of frame k before any event of frame k+1.
REQ-024 SHALL present the FIFO first-word-fall-through:
- ev_valid = FIFO not empty.
- ev_addr and ev_ts come from the head entry.
- An entry is popped on any edge with ev_valid && ev_ready.
REQ-025 SHALL give a latency of 2 cycles, with an empty FIFO and ev_ready high, from the accepting cycle to ev_valid high for the first event.
REQ-026 SHALL accept a push and a pop on the same edge when the FIFO is neither empty nor full, leaving fifo_level unchanged.
REQ-027 SHALL block a push when the FIFO is full, even if a pop occurs on the same edge; no event is ever dropped or overwritten.
REQ-028 SHALL hold ev_addr and ev_ts stable while ev_valid is high and ev_ready is low.
REQ-029 SHALL sustain one event per cycle when ev_ready is held high.

Reset
REQ-030 While rst is high, SHALL force the following on the next edge:
- FSM to IDLE; pending register, timestep counter and FIFO pointers to 0.
- fifo_level = 0, ev_valid = 0, busy = 0, spike_ready = 1.
REQ-031 SHALL let rst asserted mid-SCAN discard all pending and queued events, with no partial frame surviving.
REQ-032 SHALL give rst priority over a simultaneous spike_valid, ev_ready or push.

Structure
REQ-033 SHALL place NUM_NEURONS, TS_W, the derived address width and the event typedef {ts, addr} in the shared package snn_pkg.
REQ-034 SHALL implement the event FIFO as one sub-module, spike_event_fifo, with push/pop/full/empty/level ports; the scanner and FSM remain in spike_aer_encoder.

Verification
REQ-035 SHALL cover: after reset, frame 8'b1010_0101 with ev_ready=1 -> events addr 0,2,5,7 with ts=0 on consecutive cycles; first ev_valid 2 cycles after acceptance.
REQ-036 SHALL cover: frames 8'h00, then 8'h80 -> a single event addr 7 with ts=1; spike_ready never drops for the zero frame.
REQ-037 SHALL cover: ev_ready=0, frame 8'hFF then 8'h01 -> FIFO fills at 8, spike_ready low, no loss; releasing ev_ready yields addr 0..7 ts=0, then addr 0 ts=1.
REQ-038 SHALL cover: 256 accepted frames of 8'h01 -> ts runs 0..255 then wraps, frame 257 stamped ts=0.
REQ-039 SHALL cover: rst pulsed during SCAN of 8'hF0 after two pushes -> ev_valid=0 and fifo_level=0 next cycle; the next frame 8'h02 is stamped ts=0.
REQ-040 SHALL cover: random ev_ready backpressure over 1000 random frames -> the scoreboard matches every (addr, ts) in order, with ev_addr and ev_ts stable while stalled.
